// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid_pkg
//  Purpose  : Shared pipeline-register constants (NOP bubble, channel indices)
//             and the main-register source select encoding.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_stage_skid_pkg;

    localparam int          DEF_DATA_W = 16;
    localparam logic [15:0] NOP_BUBBLE = 16'h0000;
    localparam int          CH_NEXTPC  = 0;
    localparam int          CH_INSTR   = 1;

    // Where the main register takes its next contents from on a given edge.
    typedef enum logic [1:0] {
        SRC_HOLD  = 2'd0,
        SRC_SKID  = 2'd1,
        SRC_INPUT = 2'd2,
        SRC_EMPTY = 2'd3
    } m_src_e;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_slot.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_slot
//  Purpose  : One valid bit plus a payload register with load enable and
//             asynchronous active-low clear.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_d,
    input  logic         load,
    input  logic [W-1:0] data_d,
    output logic         valid_q,
    output logic [W-1:0] data_q
);

    // Payload only toggles on an actual load so an idle stage stays quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= data_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : Parametrised valid/ready pipeline register with optional skid
//             slot, synchronous flush and saturating dropped-beat counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                NCH    = 2,
    parameter bit                SKID   = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_BUBBLE),
    parameter int                CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic                  out_flushed,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int               FW      = NCH * DATA_W;
    localparam int               SUM_W   = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic          m_valid;
    logic [FW-1:0] m_data;
    logic          s_valid;
    logic [FW-1:0] s_data;

    logic          in_fire;
    logic          out_fire;
    m_src_e        m_src;
    logic          m_valid_d;
    logic          m_load;
    logic [FW-1:0] m_data_d;

    logic [1:0]       drop_inc;
    logic [SUM_W-1:0] drop_sum;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_valid ? m_data : {NCH{BUBBLE}};

    // The skid slot, when occupied, always refills the main register first so
    // beat order is preserved; the input can only be taken when it is empty.
    always_comb begin
        m_src = SRC_HOLD;
        if (flush) begin
            m_src = SRC_EMPTY;
        end else if (!m_valid || out_fire) begin
            if (s_valid) begin
                m_src = SRC_SKID;
            end else if (in_fire) begin
                m_src = SRC_INPUT;
            end else begin
                m_src = SRC_EMPTY;
            end
        end
    end

    always_comb begin
        m_load    = (m_src == SRC_SKID) || (m_src == SRC_INPUT);
        m_valid_d = (m_src == SRC_HOLD) ? m_valid : m_load;
        m_data_d  = (m_src == SRC_SKID) ? s_data : in_data;
    end

    pipe_slot #(.W(FW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .valid_d (m_valid_d),
        .load    (m_load),
        .data_d  (m_data_d),
        .valid_q (m_valid),
        .data_q  (m_data)
    );

    generate
        if (SKID) begin : g_skid
            logic s_load;
            logic s_valid_d;

            // Input lands in the skid slot only while the main register stalls.
            always_comb begin
                s_load    = !flush && m_valid && !out_fire && in_fire;
                s_valid_d = s_valid;
                if (flush) begin
                    s_valid_d = 1'b0;
                end else if (s_load) begin
                    s_valid_d = 1'b1;
                end else if (m_src == SRC_SKID) begin
                    s_valid_d = 1'b0;
                end
            end

            pipe_slot #(.W(FW)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .valid_d (s_valid_d),
                .load    (s_load),
                .data_d  (in_data),
                .valid_q (s_valid),
                .data_q  (s_data)
            );

            assign in_ready = ~s_valid;
        end else begin : g_no_skid
            assign s_valid  = 1'b0;
            assign s_data   = '0;
            assign in_ready = ~m_valid | out_ready;
        end
    endgenerate

    // Beats lost to a flush: a stalled main beat, a skid beat, and the input beat.
    always_comb begin
        drop_inc = {1'b0, m_valid & ~out_fire} + {1'b0, s_valid} + {1'b0, in_fire};
        drop_sum = SUM_W'(drop_cnt) + SUM_W'(drop_inc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_flushed <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (flush) begin
                out_flushed <= 1'b1;
                drop_cnt    <= (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
            end else if (m_load) begin
                out_flushed <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
